// File: rtl/instr_loader.sv
// UART boot loader: collects a little-endian word count followed by that many
// little-endian instruction words and writes them into instruction memory.
module instr_loader #(
    parameter int unsigned MAX_WORDS = 4096,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rx_valid,
    input  logic [7:0]  rx_data,
    output logic        io_sel,
    output logic        we,
    output logic        en,
    output logic [31:0] addr_io,
    output logic [31:0] din,
    output logic        done,
    output logic        err
);

    // state  | meaning
    // S_LEN  | collecting the 4-byte word count N
    // S_DATA | collecting instruction words, writing each as it completes
    // S_DONE | load finished, memory handed back to the processor
    // S_ERR  | declared count exceeded capacity, sticky until reset

    localparam int unsigned IDX_W = (MAX_WORDS > 1) ? $clog2(MAX_WORDS) : 1;
    localparam int unsigned CNT_W = $clog2(MAX_WORDS + 1);

    typedef enum logic [1:0] {
        S_LEN  = 2'd0,
        S_DATA = 2'd1,
        S_DONE = 2'd2,
        S_ERR  = 2'd3
    } state_e;

    state_e             state_q, state_d;
    logic [1:0]         byte_cnt_q;
    logic [31:0]        asm_q, asm_d;
    logic [CNT_W-1:0]   n_q;
    logic [IDX_W-1:0]   idx_q;
    logic               we_q;
    logic [31:0]        addr_q;
    logic [31:0]        din_q;

    logic               accept;
    logic               word_done;
    logic               last_word;
    logic               len_to_data;

    assign accept    = rx_valid && ((state_q == S_LEN) || (state_q == S_DATA));
    assign word_done = accept && (byte_cnt_q == 2'd3);
    assign last_word = ((CNT_W'(idx_q) + CNT_W'(1)) == n_q);
    assign len_to_data = (state_q == S_LEN) && word_done &&
                         (asm_d != 32'd0) && (asm_d <= 32'(MAX_WORDS));

    // Lane insert: the 4th byte lands in bits 31:24, completing the word in asm_d.
    always_comb begin
        asm_d = asm_q;
        asm_d[8*byte_cnt_q +: 8] = rx_data;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_LEN;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_LEN: begin
                if (word_done) begin
                    if (asm_d == 32'd0) begin
                        state_d = S_DONE;
                    end else if (asm_d > 32'(MAX_WORDS)) begin
                        state_d = S_ERR;
                    end else begin
                        state_d = S_DATA;
                    end
                end
            end
            S_DATA: begin
                if (we_q && last_word) begin
                    state_d = S_DONE;
                end
            end
            S_DONE:  state_d = S_DONE;
            S_ERR:   state_d = S_ERR;
            default: state_d = S_LEN;
        endcase
    end

    always_comb begin
        io_sel = 1'b0;
        done   = 1'b0;
        err    = 1'b0;
        case (state_q)
            S_LEN:   io_sel = 1'b1;
            S_DATA:  io_sel = 1'b1;
            S_DONE:  done   = 1'b1;
            S_ERR:   err    = 1'b1;
            default: io_sel = 1'b1;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            byte_cnt_q <= 2'd0;
            asm_q      <= 32'd0;
        end else if (accept) begin
            byte_cnt_q <= byte_cnt_q + 2'd1;
            asm_q      <= asm_d;
        end
    end

    // Index advances in the cycle after the pulse so the pulse sees the old index.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            n_q   <= '0;
            idx_q <= '0;
        end else if (len_to_data) begin
            n_q   <= asm_d[CNT_W-1:0];
            idx_q <= '0;
        end else if ((state_q == S_DATA) && we_q && !last_word) begin
            idx_q <= idx_q + IDX_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            we_q   <= 1'b0;
            addr_q <= BASE_ADDR;
            din_q  <= 32'd0;
        end else begin
            we_q <= (state_q == S_DATA) && word_done;
            if ((state_q == S_DATA) && word_done) begin
                addr_q <= BASE_ADDR + (32'(idx_q) << 2);
                din_q  <= asm_d;
            end
        end
    end

    assign we      = we_q;
    assign en      = we_q;
    assign addr_io = addr_q;
    assign din     = din_q;

endmodule

// File: tb/tb_instr_loader.sv
// Scoreboard bench for instr_loader: a byte-level stream model predicts each
// memory write; a negedge monitor pops and compares every write pulse.
module tb_instr_loader;

    localparam int unsigned MAXW = 4096;
    localparam logic [31:0] BASE = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rx_valid = 1'b0;
    logic [7:0]  rx_data = 8'h00;
    logic        io_sel, we, en, done, err;
    logic [31:0] addr_io, din;

    instr_loader dut (
        .clk(clk), .rst(rst), .rx_valid(rx_valid), .rx_data(rx_data),
        .io_sel(io_sel), .we(we), .en(en), .addr_io(addr_io), .din(din),
        .done(done), .err(err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc = cyc + 1;

    int errors = 0;
    int checks = 0;

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks = checks + 1;
        if (act !== exp) begin
            errors = errors + 1;
            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        int          c;
        bit          last;
    } exp_t;

    exp_t sb[$];

    // Reference model of the stream protocol
    typedef enum {M_LEN, M_DATA, M_DONE, M_ERR} mphase_e;
    mphase_e     m_phase = M_LEN;
    logic [7:0]  m_buf[4];
    int          m_bcnt = 0;
    longint      m_n = 0;
    int          m_idx = 0;

    function automatic void model_reset();
        m_phase = M_LEN;
        m_bcnt  = 0;
        m_n     = 0;
        m_idx   = 0;
        sb.delete();
    endfunction

    function automatic void model_byte(input logic [7:0] b);
        logic [31:0] w;
        if (m_phase != M_LEN && m_phase != M_DATA) return;
        m_buf[m_bcnt] = b;
        m_bcnt = m_bcnt + 1;
        if (m_bcnt < 4) return;
        m_bcnt = 0;
        w = {m_buf[3], m_buf[2], m_buf[1], m_buf[0]};
        if (m_phase == M_LEN) begin
            if (w == 0)             m_phase = M_DONE;
            else if (w > MAXW)      m_phase = M_ERR;
            else begin
                m_phase = M_DATA;
                m_n     = w;
                m_idx   = 0;
            end
        end else begin
            sb.push_back('{addr: BASE + 32'(m_idx) * 4, data: w, c: cyc,
                           last: (m_idx == m_n - 1)});
            m_idx = m_idx + 1;
            if (m_idx == m_n) m_phase = M_DONE;
        end
    endfunction

    // Monitor
    bit pend_done = 0;
    always @(negedge clk) begin
        if (!rst) begin
            if (pend_done) begin
                check("done_after_last", {31'd0, done}, 32'd1);
                check("iosel_after_last", {31'd0, io_sel}, 32'd0);
                pend_done = 0;
            end
            if (we) begin
                if (sb.size() == 0) begin
                    check("unexpected_we", {31'd0, we}, 32'd0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    check("wr_addr", addr_io, e.addr);
                    check("wr_data", din, e.data);
                    check("wr_latency", 32'(cyc), 32'(e.c));
                    check("wr_en", {31'd0, en}, 32'd1);
                    check("wr_iosel", {31'd0, io_sel}, 32'd1);
                    pend_done = e.last;
                end
            end
        end
    end

    int gap_max = 0;

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_valid = 1'b1;
        rx_data  = b;
        @(posedge clk);
        #1;
        rx_valid = 1'b0;
        model_byte(b);
        if (gap_max > 0) idle($urandom_range(0, gap_max));
    endtask

    task automatic send_word(input logic [31:0] w);
        for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8]);
    endtask

    task automatic do_reset();
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        check("rst_iosel", {31'd0, io_sel}, 32'd1);
        check("rst_we",    {31'd0, we},     32'd0);
        check("rst_en",    {31'd0, en},     32'd0);
        check("rst_addr",  addr_io,         BASE);
        check("rst_din",   din,             32'd0);
        check("rst_done",  {31'd0, done},   32'd0);
        check("rst_err",   {31'd0, err},    32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic check_status(input string tag);
        idle(3);
        check({tag, "_pending"}, 32'(sb.size()), 32'd0);
        check({tag, "_done"},  {31'd0, done},   {31'd0, m_phase == M_DONE});
        check({tag, "_err"},   {31'd0, err},    {31'd0, m_phase == M_ERR});
        check({tag, "_iosel"}, {31'd0, io_sel}, {31'd0, m_phase == M_LEN || m_phase == M_DATA});
    endtask

    initial begin
        idle(2);
        do_reset();

        // Single word
        send_word(32'd1);
        send_word(32'h0000_0013);
        check_status("one_word");

        // Three words back-to-back
        do_reset();
        send_word(32'd3);
        send_word(32'h0000_000A);
        send_word(32'h0000_000B);
        send_word(32'h0000_000C);
        check_status("three_words");

        // Zero-length load finishes one cycle after the 4th byte
        do_reset();
        send_word(32'd0);
        check("n0_done_latency", {31'd0, done}, 32'd1);
        check("n0_iosel", {31'd0, io_sel}, 32'd0);
        check_status("n0");
        for (int i = 0; i < 8; i++) send_byte(8'($urandom));
        check_status("after_done");

        // Oversize count
        do_reset();
        send_word(32'd4097);
        check("err_latency", {31'd0, err}, 32'd1);
        for (int i = 0; i < 8; i++) send_byte(8'($urandom));
        check_status("oversize");

        // Exactly at capacity is accepted
        do_reset();
        send_word(MAXW);
        check_status("cap_len");

        // Reset mid-load discards partial state
        do_reset();
        send_word(32'd2);
        send_byte(8'h55);
        send_byte(8'h66);
        do_reset();
        send_word(32'd1);
        send_word(32'hDEAD_BEEF);
        check_status("rst_midload");

        // Randomized loads with random byte gaps
        for (int t = 0; t < 8; t++) begin
            int n;
            do_reset();
            gap_max = t % 3;
            n = (t == 7) ? 5000 + $urandom_range(0, 1000) : $urandom_range(1, 8);
            send_word(32'(n));
            if (n <= MAXW) begin
                for (int k = 0; k < n; k++) send_word($urandom);
            end
            for (int i = 0; i < 8; i++) send_byte(8'($urandom));
            check_status("random");
        end
        gap_max = 0;

        idle(2);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
